// File: rtl/pong_rnd_pkg.sv
// Shared types and helpers for the random-number scheduler.
`include "config.svh"

package pong_rnd_pkg;
    localparam int W = `RND_NUM_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_e;

    // Smallest all-ones value >= lim: smear the top set bit downwards.
    function automatic logic [W-1:0] mask_of(input logic [W-1:0] lim);
        logic [W-1:0] m;
        m = lim;
        for (int i = 0; i < W; i++) m = m | (m >> 1);
        return m;
    endfunction
endpackage

// File: rtl/config.svh
// Build-wide random-source configuration shared by the scheduler and its package.
`ifndef RND_CONFIG_SVH
`define RND_CONFIG_SVH
`define RND_NUM_W 8
`define RND_SEED  8'hB5
`endif

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping past N-1.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    int j;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/rnd_scheduler.sv
// Shares one LFSR among N_REQ requesters, returning a uniform draw in 0..limit
// by rejection sampling with a bounded number of attempts.
module rnd_scheduler
    import pong_rnd_pkg::*;
#(
    parameter int             N_REQ   = 3,
    parameter logic [W-1:0]   TAPS    = W'(5) << (W - 3),
    parameter int             MAX_TRY = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ*W-1:0]   limit_i,
    input  logic                 reseed_i,
    input  logic [W-1:0]         seed_i,
    output logic                 rnd_valid_o,
    output logic [N_REQ-1:0]     rnd_gnt_o,
    output logic [W-1:0]         rnd_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(MAX_TRY + 1);

    state_e           state_q, state_d;
    logic [W-1:0]     lfsr_q, lfsr_d, lim_q, lim_d, rnd_q, rnd_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d, idx_q, idx_d;
    logic [TW-1:0]    try_q, try_d;
    logic [N_REQ-1:0] gsel_q, gsel_d, gnt_q, gnt_d;
    logic             valid_q, valid_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic [W-1:0]     mask, cand;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign mask = mask_of(lim_q);
    assign cand = lfsr_q & mask;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        lim_d    = lim_q;
        rnd_d    = rnd_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        try_d    = try_q;
        gsel_d   = gsel_q;
        gnt_d    = '0;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A reseed cycle deliberately issues no grant.
                if (reseed_i) begin
                    lfsr_d = (seed_i == '0) ? W'(`RND_SEED) : seed_i;
                end else if (|req_i) begin
                    idx_d   = arb_idx;
                    gsel_d  = arb_gnt;
                    lim_d   = limit_i[arb_idx*W +: W];
                    try_d   = '0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
                if (cand <= lim_q) begin
                    rnd_d   = cand;
                    valid_d = 1'b1;
                    gnt_d   = gsel_q;
                    state_d = S_DONE;
                end else if (try_q == TW'(MAX_TRY - 1)) begin
                    // Dropping the top mask bit guarantees an in-range fallback.
                    rnd_d   = cand & (mask >> 1);
                    valid_d = 1'b1;
                    gnt_d   = gsel_q;
                    state_d = S_DONE;
                end else begin
                    try_d = try_q + 1'b1;
                end
            end
            S_DONE: begin
                rr_ptr_d = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            lfsr_q   <= W'(`RND_SEED);
            lim_q    <= '0;
            rnd_q    <= '0;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            try_q    <= '0;
            gsel_q   <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            lim_q    <= lim_d;
            rnd_q    <= rnd_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            try_q    <= try_d;
            gsel_q   <= gsel_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
        end
    end

    assign rnd_valid_o = valid_q;
    assign rnd_gnt_o   = gnt_q;
    assign rnd_o       = rnd_q;
endmodule

// File: tb/tb_rnd_scheduler.sv
// Directed bench for rnd_scheduler: W=8, TAPS=8'hA0, seed constant 8'hB5.
module tb_rnd_scheduler;
    localparam int          N    = 3;
    localparam int          W    = 8;
    localparam logic [7:0]  SEED = 8'hB5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req, req1;
    logic [N*W-1:0]   limit, limit1;
    logic             reseed, reseed1;
    logic [W-1:0]     seed, seed1;
    logic             vld, vld1;
    logic [N-1:0]     gnt, gnt1;
    logic [W-1:0]     rnd, rnd1;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rnd_scheduler #(.N_REQ(N), .TAPS(8'hA0), .MAX_TRY(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .limit_i(limit),
        .reseed_i(reseed), .seed_i(seed),
        .rnd_valid_o(vld), .rnd_gnt_o(gnt), .rnd_o(rnd)
    );

    rnd_scheduler #(.N_REQ(N), .TAPS(8'hA0), .MAX_TRY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .limit_i(limit1),
        .reseed_i(reseed1), .seed_i(seed1),
        .rnd_valid_o(vld1), .rnd_gnt_o(gnt1), .rnd_o(rnd1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [N-1:0] g, input logic [W-1:0] r);
        chk({tag, ".valid"}, 32'(vld), 32'(v));
        chk({tag, ".gnt"},   32'(gnt), 32'(g));
        chk({tag, ".rnd"},   32'(rnd), 32'(r));
    endtask

    initial begin
        rst_n = 1'b0; req = '0; limit = '0; reseed = 1'b0; seed = '0;
        req1 = '0; limit1 = '0; reseed1 = 1'b0; seed1 = '0;
        tick(); tick();
        chk_out("reset", 1'b0, 3'b000, 8'h00);
        rst_n = 1'b1;

        // Seed 01, limit 5: accepted first DRAW, dropped request still served
        reseed = 1'b1; seed = 8'h01; tick(); reseed = 1'b0;
        chk("reseed_nogrant", 32'(vld), 32'h0);
        req = 3'b001; limit = {8'd0, 8'd0, 8'd5}; tick();
        chk("t1_lat", 32'(vld), 32'h0);
        req = '0; tick();
        chk_out("t2", 1'b1, 3'b001, 8'h01);
        tick();
        chk_out("t2_after", 1'b0, 3'b000, 8'h01);

        // Seed 06, limit 4: 6 rejected, then 0C&7=4; later limit change ignored
        reseed = 1'b1; seed = 8'h06; tick(); reseed = 1'b0;
        req = 3'b001; limit = {8'd0, 8'd0, 8'd4}; tick();
        req = '0; limit = {8'hFF, 8'hFF, 8'hFF}; tick();
        chk("reject_cycle", 32'(vld), 32'h0);
        tick();
        chk_out("t3_accept", 1'b1, 3'b001, 8'h04);
        tick();

        // Seed 0 loads B5; reseed during DRAW/DONE ignored, next draw sees 6A
        reseed = 1'b1; seed = 8'h00; tick(); reseed = 1'b0;
        req = 3'b001; tick();
        req = '0; reseed = 1'b1; seed = 8'h01; tick();
        chk_out("seed0", 1'b1, 3'b001, SEED);
        tick(); reseed = 1'b0;
        req = 3'b001; tick();
        req = '0; tick();
        chk_out("reseed_ignored", 1'b1, 3'b001, 8'h6A);
        tick();

        // Grant idx1 moves rr_ptr to 2
        req = 3'b010; tick();
        req = '0; tick();
        chk_out("idx1", 1'b1, 3'b010, 8'hD5);
        tick();

        // Reset while in DRAW: no pulse, then seed and pointer back to reset values
        req = 3'b001; tick();
        req = '0; rst_n = 1'b0; #1;
        chk("rst_async", 32'(vld), 32'h0);
        tick();
        chk_out("rst_in_draw", 1'b0, 3'b000, 8'h00);
        rst_n = 1'b1; tick();
        chk("no_stray", 32'(vld), 32'h0);
        req = 3'b110; tick();
        req = '0; tick();
        chk_out("post_rst", 1'b1, 3'b010, SEED);
        tick();

        // Reset, then all requesting with limit 0: rotating grants, result 0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 3'b111; limit = '0;
        begin
            logic [N-1:0] exp_g [4];
            exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
            for (int i = 0; i < 4; i++) begin
                tick(); tick();
                chk_out($sformatf("rr%0d", i), 1'b1, exp_g[i], 8'h00);
                tick();
                chk($sformatf("rr%0d_gap", i), 32'(vld), 32'h0);
            end
        end
        req = '0;

        // MAX_TRY=1: first rejection falls back to 6 & 3 = 2
        reseed1 = 1'b1; seed1 = 8'h06; tick(); reseed1 = 1'b0;
        req1 = 3'b001; limit1 = {8'd0, 8'd0, 8'd4}; tick();
        req1 = '0; tick();
        chk("fb.valid", 32'(vld1), 32'h1);
        chk("fb.gnt",   32'(gnt1), 32'h1);
        chk("fb.rnd",   32'(rnd1), 32'h2);
        tick();
        chk("fb.after", 32'(vld1), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
